// File: rtl/gf180mcu_fd_sc_mcu9t5v0__addf_serctl.sv
// Bit-serial sequencer and two-requester round-robin arbiter for one shared full-adder cell.
// Optional subtract mode (SUB0/SUB1 ports) when GF180MCU_FD_SC_MCU9T5V0__ADDF_SERCTL_SUB_EN is defined.
//
// state    | meaning
// ST_IDLE  | no operation; arbitrate pending requests, grant on the clock edge
// ST_RUN   | one operand bit per cycle through the shared adder, LSB first
// ST_FIN   | last bit absorbed; publish sum/carry, DONE pulses in the following cycle
module gf180mcu_fd_sc_mcu9t5v0__addf_serctl #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         REQ0,
    input  logic [W-1:0] A0,
    input  logic [W-1:0] B0,
    input  logic         CI0,
    output logic         GNT0,
    input  logic         REQ1,
    input  logic [W-1:0] A1,
    input  logic [W-1:0] B1,
    input  logic         CI1,
    output logic         GNT1,
`ifdef GF180MCU_FD_SC_MCU9T5V0__ADDF_SERCTL_SUB_EN
    input  logic         SUB0,
    input  logic         SUB1,
`endif
    output logic         FA_A,
    output logic         FA_B,
    output logic         FA_CI,
    input  logic         FA_S,
    input  logic         FA_CO,
    output logic         BUSY,
    output logic         DONE,
    output logic         ID,
    output logic [W-1:0] S_OUT,
    output logic         CO_OUT
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  s_sh;
    logic          c;
    logic [CW-1:0] cnt;
    logic          rr_last;

    logic          req_any;
    logic          gnt_sel;
    logic [W-1:0]  sel_a;
    logic [W-1:0]  sel_b;
    logic          sel_ci;
    logic [W-1:0]  b_load;
    logic          c_load;

    // With both requesting, the requester not served last wins.
    always_comb begin
        req_any = REQ0 | REQ1;
        gnt_sel = (REQ0 & REQ1) ? ~rr_last : REQ1;
        sel_a   = gnt_sel ? A1  : A0;
        sel_b   = gnt_sel ? B1  : B0;
        sel_ci  = gnt_sel ? CI1 : CI0;
    end

`ifdef GF180MCU_FD_SC_MCU9T5V0__ADDF_SERCTL_SUB_EN
    logic sel_sub;
    // A - B computed as A + ~B + 1; carry-out high means no borrow.
    always_comb begin
        sel_sub = gnt_sel ? SUB1 : SUB0;
        b_load  = sel_sub ? ~sel_b : sel_b;
        c_load  = sel_sub ? 1'b1 : sel_ci;
    end
`else
    always_comb begin
        b_load = sel_b;
        c_load = sel_ci;
    end
`endif

    // Shared cell is held quiet except while bits are streaming.
    always_comb begin
        FA_A  = 1'b0;
        FA_B  = 1'b0;
        FA_CI = 1'b0;
        if (state == ST_RUN) begin
            FA_A  = a_sh[0];
            FA_B  = b_sh[0];
            FA_CI = c;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            s_sh    <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            rr_last <= 1'b1;
            GNT0    <= 1'b0;
            GNT1    <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ID      <= 1'b0;
            S_OUT   <= '0;
            CO_OUT  <= 1'b0;
        end else begin
            GNT0 <= 1'b0;
            GNT1 <= 1'b0;
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    BUSY <= 1'b0;
                    if (req_any) begin
                        GNT0  <= ~gnt_sel;
                        GNT1  <= gnt_sel;
                        a_sh  <= sel_a;
                        b_sh  <= b_load;
                        c     <= c_load;
                        ID    <= gnt_sel;
                        BUSY  <= 1'b1;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    s_sh <= {FA_S, s_sh[W-1:1]};
                    c    <= FA_CO;
                    a_sh <= {1'b0, a_sh[W-1:1]};
                    b_sh <= {1'b0, b_sh[W-1:1]};
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    // BUSY stays high through the DONE cycle and drops in IDLE.
                    DONE    <= 1'b1;
                    S_OUT   <= s_sh;
                    CO_OUT  <= c;
                    rr_last <= ID;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__addf_serctl.sv
// Directed self-checking bench for the serial full-adder sequencer/arbiter (W=8).
// The shared adder cell is modelled here as a plain combinational full adder.
module tb_gf180mcu_fd_sc_mcu9t5v0__addf_serctl;

    localparam int W = 8;

    logic         CLK;
    logic         RST;
    logic         REQ0, REQ1;
    logic [W-1:0] A0, B0, A1, B1;
    logic         CI0, CI1;
    logic         GNT0, GNT1;
    logic         FA_A, FA_B, FA_CI, FA_S, FA_CO;
    logic         BUSY, DONE, ID, CO_OUT;
    logic [W-1:0] S_OUT;
`ifdef GF180MCU_FD_SC_MCU9T5V0__ADDF_SERCTL_SUB_EN
    logic         SUB0, SUB1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    gf180mcu_fd_sc_mcu9t5v0__addf_serctl #(.W(W)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .A0(A0), .B0(B0), .CI0(CI0), .GNT0(GNT0),
        .REQ1(REQ1), .A1(A1), .B1(B1), .CI1(CI1), .GNT1(GNT1),
`ifdef GF180MCU_FD_SC_MCU9T5V0__ADDF_SERCTL_SUB_EN
        .SUB0(SUB0), .SUB1(SUB1),
`endif
        .FA_A(FA_A), .FA_B(FA_B), .FA_CI(FA_CI), .FA_S(FA_S), .FA_CO(FA_CO),
        .BUSY(BUSY), .DONE(DONE), .ID(ID), .S_OUT(S_OUT), .CO_OUT(CO_OUT)
    );

    assign FA_S  = FA_A ^ FA_B ^ FA_CI;
    assign FA_CO = (FA_A & FA_B) | (FA_A & FA_CI) | (FA_B & FA_CI);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation from requester r with REQ dropped once GNT is seen.
    task automatic do_op(input string tag, input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sub, input logic [W-1:0] es, input logic eco);
        int n;
        if (r) begin
            REQ1 = 1'b1; A1 = a; B1 = b; CI1 = ci;
        end else begin
            REQ0 = 1'b1; A0 = a; B0 = b; CI0 = ci;
        end
`ifdef GF180MCU_FD_SC_MCU9T5V0__ADDF_SERCTL_SUB_EN
        SUB0 = sub; SUB1 = sub;
`endif
        n = 0;
        do begin @(negedge CLK); n++; end while (!(r ? GNT1 : GNT0) && n < 20);
        chk({tag, "_gnt"}, 32'(r ? GNT1 : GNT0), 32'd1);
        chk({tag, "_fa_ci0"}, 32'(FA_CI), 32'(sub | ci));
        chk({tag, "_fa_a0"}, 32'(FA_A), 32'(a[0]));
        REQ0 = 1'b0; REQ1 = 1'b0;
        @(negedge CLK);
        chk({tag, "_gnt_1cyc"}, 32'(GNT0 | GNT1), 32'd0);
        n = 1;
        while (!DONE && n < 40) begin @(negedge CLK); n++; end
        chk({tag, "_latency"}, 32'(n), 32'(W + 1));
        chk({tag, "_s"}, 32'(S_OUT), 32'(es));
        chk({tag, "_co"}, 32'(CO_OUT), 32'(eco));
        chk({tag, "_id"}, 32'(ID), 32'(r));
        chk({tag, "_busy_done"}, 32'(BUSY), 32'd1);
        @(negedge CLK);
        chk({tag, "_done_1cyc"}, 32'(DONE), 32'd0);
        chk({tag, "_busy_end"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        logic exp_r;
        RST = 1'b1;
        REQ0 = 1'b0; REQ1 = 1'b0;
        A0 = '0; B0 = '0; A1 = '0; B1 = '0; CI0 = 1'b0; CI1 = 1'b0;
`ifdef GF180MCU_FD_SC_MCU9T5V0__ADDF_SERCTL_SUB_EN
        SUB0 = 1'b0; SUB1 = 1'b0;
`endif
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_outs", {21'd0, GNT0, GNT1, BUSY, DONE, ID, CO_OUT, FA_A, FA_B, FA_CI, 2'b00}, 32'd0);
        chk("rst_s", 32'(S_OUT), 32'd0);
        RST = 1'b0;

        // Idle: no requests for 20 cycles.
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (FA_A | FA_B | FA_CI | BUSY | GNT0 | GNT1 | DONE) seen++;
        end
        chk("idle_quiet", 32'(seen), 32'd0);

        // Both requesting and held: expect 0,1,0,1 with W+2 cycle spacing.
        A0 = 8'h12; B0 = 8'h34; CI0 = 1'b0;
        A1 = 8'h80; B1 = 8'h80; CI1 = 1'b1;
        REQ0 = 1'b1; REQ1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_r = (i % 2) != 0;
            n = 0;
            do begin @(negedge CLK); n++; end while (!(GNT0 | GNT1) && n < 20);
            chk("alt_gap", 32'(n), 32'd1);
            chk("alt_gnt", {30'd0, GNT1, GNT0}, exp_r ? 32'd2 : 32'd1);
            n = 0;
            do begin @(negedge CLK); n++; end while (!DONE && n < 40);
            chk("alt_latency", 32'(n), 32'(W + 1));
            chk("alt_id", 32'(ID), 32'(exp_r));
            chk("alt_s", 32'(S_OUT), exp_r ? 32'h01 : 32'h46);
            chk("alt_co", 32'(CO_OUT), exp_r ? 32'd1 : 32'd0);
            if (i == 3) begin
                REQ0 = 1'b0; REQ1 = 1'b0;
            end
        end
        @(negedge CLK);
        chk("alt_idle_busy", 32'(BUSY), 32'd0);

        do_op("add0", 1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
        do_op("add1", 1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1);

        // Reset while bit 3 is in flight.
        REQ1 = 1'b1; A1 = 8'hFF; B1 = 8'h01; CI1 = 1'b0;
        n = 0;
        do begin @(negedge CLK); n++; end while (!GNT1 && n < 20);
        chk("mid_gnt", 32'(GNT1), 32'd1);
        REQ1 = 1'b0;
        repeat (3) @(negedge CLK);
        chk("mid_fa_a_live", 32'(FA_A), 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_outs", {22'd0, GNT0, GNT1, BUSY, DONE, ID, CO_OUT, FA_A, FA_B, FA_CI, 1'b0}, 32'd0);
        chk("mid_rst_s", 32'(S_OUT), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge CLK);
            if (DONE | BUSY) seen++;
        end
        chk("mid_no_done", 32'(seen), 32'd0);
        do_op("post_rst", 1'b0, 8'h33, 8'h44, 1'b1, 1'b0, 8'h78, 1'b0);

`ifdef GF180MCU_FD_SC_MCU9T5V0__ADDF_SERCTL_SUB_EN
        do_op("sub_borrow", 1'b0, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0);
        do_op("sub_ok", 1'b0, 8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
